// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: funct3 size codes, FSM states and request record for the data-memory responder
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte enables/lane data, load lane extract and extension, fault decode
module dmem_lane_align
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [31:0]           rword,
    output logic [3:0]            be,
    output logic [31:0]           wdata_al,
    output logic [31:0]           rdata_ext,
    output logic                  fault
);

    logic [1:0]  off;
    logic [31:0] lane;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;

    // size decode from funct3[1:0]; the lane is shifted down so extension always starts at bit 0
    always_comb begin
        off          = addr[1:0];
        lane         = rword >> {off, 3'b000};
        be           = (funct3[1:0] == 2'b00) ? 4'b0001 << off :
                       (funct3[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
        wdata_al     = (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
                       (funct3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
        rdata_ext    = (funct3 == F3_B)  ? {{24{lane[7]}}, lane[7:0]} :
                       (funct3 == F3_H)  ? {{16{lane[15]}}, lane[15:0]} :
                       (funct3 == F3_BU) ? {24'b0, lane[7:0]} :
                       (funct3 == F3_HU) ? {16'b0, lane[15:0]} : rword;
        illegal      = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
        misaligned   = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
        out_of_range = (addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS);
        fault        = illegal || misaligned || out_of_range || (write && funct3[2]);
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-memory responder with sizing, faults and wait states
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault
);

    localparam int IW = $clog2(DEPTH_WORDS);

    dmem_state_t   state;
    dmem_state_t   state_nx;
    mem_req_t      req_q;
    mem_req_t      cur;
    logic [3:0]    cnt_q;
    logic          live;
    logic          accept;
    logic          access;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wdata_al;
    logic [31:0]   rdata_ext;
    logic [IW-1:0] widx;
    logic [31:0]   mem [DEPTH_WORDS];

    // in IDLE the live request is decoded directly so a zero-wait access can happen on the accept edge
    assign req_ready = live && state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_valid && req_ready;
    assign cur       = (state == IDLE) ? mem_req_t'({req_write, req_funct3, 32'(req_addr), req_wdata}) : req_q;
    assign widx      = cur.addr[IW+1:2];

    dmem_lane_align #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_align (
        .write     (cur.write),
        .funct3    (cur.funct3),
        .addr      (cur.addr[ADDR_WIDTH-1:0]),
        .wdata     (cur.wdata),
        .rword     (mem[widx]),
        .be        (be),
        .wdata_al  (wdata_al),
        .rdata_ext (rdata_ext),
        .fault     (fault)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and access strobe; no access is allowed on an edge that also resets
    always_comb begin
        state_nx = state;
        access   = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                state_nx = (fault || WAIT_STATES == 0) ? RESP : WAIT;
                access   = !fault && WAIT_STATES == 0;
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_nx = RESP;
                access   = 1'b1;
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        access = access && rst_n;
    end

    // held request, wait counter and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live      <= 1'b0;
            cnt_q     <= '0;
            req_q     <= '0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                req_q     <= cur;
                cnt_q     <= 4'(WAIT_STATES - 1);
                rsp_fault <= fault;
                rsp_rdata <= '0;
            end else if (state == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (access) rsp_rdata <= cur.write ? '0 : rdata_ext;
        end
    end

    // byte-enabled store into the array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (access && cur.write)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wdata_al[8*b +: 8];
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks against a byte-level memory model
module tb_data_mem_responder;

    localparam int WS    = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    data_mem_responder #(
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic fault_of(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (a % sz(f3) != 0) return 1'b1;
        if (a / 4 >= DEPTH) return 1'b1;
        return w && f3 >= 3'd4;
    endfunction

    // behavioural model: bytes of the low 64 addresses, one outstanding request
    logic [7:0]  mb [64];
    logic        started = 1'b0;
    logic        live_m  = 1'b0;
    logic        busy    = 1'b0;
    logic        m_done  = 1'b0;
    logic        ev;
    int          a_cyc, m_d, s;
    logic        m_w, m_flt;
    logic [2:0]  m_f3;
    logic [31:0] m_a, m_wd, m_rd, v;
    logic [5:0]  ix;

    always @(negedge clk) begin
        if (busy && !m_done && cyc >= a_cyc + m_d) begin
            if (!m_flt) begin
                s = sz(m_f3);
                if (m_w) begin
                    for (int i = 0; i < s; i++) begin
                        ix = m_a[5:0] + 6'(i);
                        mb[ix] = 8'(m_wd >> (8 * i));
                    end
                end else begin
                    v = 0;
                    for (int i = 0; i < s; i++) begin
                        ix = m_a[5:0] + 6'(i);
                        v = v | (32'(mb[ix]) << (8 * i));
                    end
                    if (!m_f3[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8 * s));
                    m_rd = v;
                end
            end
            m_done = 1'b1;
        end
        ev = busy && m_done;
        if (started) begin
            chk("req_ready", 32'(req_ready), 32'(!busy && live_m));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, m_rd);
                chk("rsp_fault", 32'(rsp_fault), 32'(m_flt));
            end
        end
        if (!rst_n) begin
            started = 1'b1;
            busy    = 1'b0;
            live_m  = 1'b0;
        end else begin
            if (ev && rsp_ready) busy = 1'b0;
            else if (!busy && live_m && req_valid) begin
                busy   = 1'b1;
                m_done = 1'b0;
                a_cyc  = cyc + 1;
                m_w    = req_write;
                m_f3   = req_funct3;
                m_a    = req_addr;
                m_wd   = req_wdata;
                m_flt  = fault_of(req_write, req_funct3, req_addr);
                m_d    = m_flt ? 0 : WS;
                m_rd   = 0;
            end
            live_m = started;
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_bad++;
            $display("FAIL accept_timeout: req_ready never rose");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic flt, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) begin
            n_bad++;
            $display("FAIL rsp_timeout: rsp_valid never rose");
        end
        rsp_ready = (hold == 0);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        rd  = rsp_rdata;
        flt = rsp_fault;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic flt, output int lat);
        issue(w, f3, a, wd);
        wait_accept();
        req_valid = 1'b0;
        wait_rsp(hold, rd, flt, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt;
        int          lat;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 0;
        req_wdata  = 0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) xact(1'b1, 3'b010, 32'(i * 4), (i == 8) ? 32'h0 : $urandom, 0, rd, flt, lat);

        rst_n = 1'b0;
        issue(1'b1, 3'b010, 32'h30, 32'hAAAA_5555);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'h1);
        xact(1'b0, 3'b010, 32'h30, 0, 0, rd, flt, lat);

        xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rd, flt, lat);
        chk("sw_lat", 32'(lat), 32'd3);
        chk("sw_fault", 32'(flt), 32'h0);
        chk("sw_rdata", rd, 32'h0);
        xact(1'b0, 3'b010, 32'h10, 0, 0, rd, flt, lat);
        chk("lw_10", rd, 32'hDEAD_BEEF);
        xact(1'b1, 3'b000, 32'h13, 32'h80, 0, rd, flt, lat);
        xact(1'b0, 3'b000, 32'h13, 0, 0, rd, flt, lat);
        chk("lb_13", rd, 32'hFFFF_FF80);
        xact(1'b0, 3'b100, 32'h13, 0, 0, rd, flt, lat);
        chk("lbu_13", rd, 32'h0000_0080);
        xact(1'b0, 3'b010, 32'h10, 0, 0, rd, flt, lat);
        chk("lw_10_after_sb", rd, 32'h80AD_BEEF);
        xact(1'b0, 3'b101, 32'h12, 0, 0, rd, flt, lat);
        chk("lhu_12", rd, 32'h0000_80AD);

        xact(1'b0, 3'b001, 32'h11, 0, 0, rd, flt, lat);
        chk("lh_mis_lat", 32'(lat), 32'd1);
        chk("lh_mis_fault", 32'(flt), 32'h1);
        chk("lh_mis_rdata", rd, 32'h0);
        xact(1'b1, 3'b010, 32'h12, 32'h1111_2222, 0, rd, flt, lat);
        chk("sw_mis_fault", 32'(flt), 32'h1);
        xact(1'b0, 3'b010, 32'h10, 0, 0, rd, flt, lat);
        chk("lw_10_unchanged", rd, 32'h80AD_BEEF);
        xact(1'b0, 3'b010, 32'(4 * DEPTH), 0, 0, rd, flt, lat);
        chk("lw_oor_fault", 32'(flt), 32'h1);
        xact(1'b0, 3'b011, 32'h10, 0, 0, rd, flt, lat);
        chk("f3_011_fault", 32'(flt), 32'h1);
        xact(1'b1, 3'b100, 32'h10, 32'h55, 0, rd, flt, lat);
        chk("sbu_fault", 32'(flt), 32'h1);

        issue(1'b0, 3'b010, 32'h10, 0);
        wait_accept();
        issue(1'b0, 3'b100, 32'h10, 0);
        wait_rsp(5, rd, flt, lat);
        chk("bp_lw", rd, 32'h80AD_BEEF);
        chk("ready_after_hs", 32'(req_ready), 32'h1);
        wait_accept();
        req_valid = 1'b0;
        wait_rsp(0, rd, flt, lat);
        chk("bp_lbu", rd, 32'h0000_00EF);

        issue(1'b1, 3'b010, 32'h20, 32'h1234_5678);
        wait_accept();
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xact(1'b0, 3'b010, 32'h20, 0, 0, rd, flt, lat);
        chk("lw_20_after_rst", rd, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 63) : $urandom_range(0, 63);
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3), rd, flt, lat);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
